sysbus_mem_responder: RTL and testbench
=======================================

// Module: sysbus_mem_responder
// PURPOSE
//  Memory-side responder for the Sysbus line-transfer protocol. Accepts 64B line-read and
//  line-writeback requests from the data-memory initiator, serves reads from an internal
//  word array as 8 response beats and commits writeback beats. Also injects single-beat
//  invalidate messages (tag 13'h0800). Used as the bus end in unit/system benches.
// PARAMETERS
//  BUS_DATA_WIDTH  64    data/address beat width
//  BUS_TAG_WIDTH   13    tag width; [12]=1 read / 0 write, [11:8]=requester id
//  MEM_WORDS       4096  backing store depth in 64-bit words (power of 2)
//  READ_LATENCY    4     cycles from read acceptance to first response beat (>=1)
// PORTS
//  clk           in   1    clock
//  reset         in   1    synchronous, active-high reset
//  bus_reqcyc    in   1    request beat valid
//  bus_req       in   64   address beat, then write data beats
//  bus_reqtag    in   13   request tag (sampled on the address beat)
//  bus_reqack    out  1    beat accepted (registered one-cycle pulse)
//  bus_respcyc   out  1    response beat valid
//  bus_resp      out  64   response data / invalidate address
//  bus_resptag   out  13   echoed request tag, or 13'h0800 for invalidate
//  bus_respack   in   1    initiator consumed the current response beat
//  inv_valid     in   1    invalidate request from the bench/coherence source
//  inv_addr      in   64   physical address to invalidate
//  inv_ready     out  1    invalidate accepted when inv_valid&&inv_ready
//  busy          out  1    state != IDLE
// BEHAVIOUR
//  - One clock domain, synchronous active-high reset. Reset: all outputs 0, state IDLE.
//    Array contents are NOT cleared. Reset mid-operation aborts; outputs are 0 the
//    following cycle. Write beats already committed stay committed.
//  - States: IDLE, WR_DATA, RD_LAT, RD_RESP, INV_RESP.
//  - Beat acceptance: when reqcyc=1 and reqack=0 in IDLE/WR_DATA, reqack=1 the next cycle.
//    That edge consumes the beat and reqack returns to 0. Every beat costs 2 cycles.
//    The initiator holds the beat until it sees reqack.
//  - Line base word = addr[6+:log2(MEM_WORDS/8)]*8. addr[5:0] is ignored.
//    Addresses beyond the array wrap modulo MEM_WORDS*8 bytes.
//  - IDLE: inv_ready=1 only in IDLE. Invalidate has priority over a simultaneous reqcyc;
//    no reqack is issued that cycle.
//    If reqcyc is high and no invalidate is pending, accept the address beat, latch tag/base:
//    tag[12]=1 -> RD_LAT (counter=READ_LATENCY); tag[12]=0 -> WR_DATA (beat cnt=0).
//  - WR_DATA: accept 8 data beats. Beat k is written to word base+k on its acceptance edge.
//    After beat 7 -> IDLE. No response beats for writes.
//  - RD_LAT: decrement counter; at 0 -> RD_RESP with beat 0 presented.
//  - RD_RESP: respcyc=1, resp=mem[base+k], resptag=latched tag. Advance k on respcyc&&respack.
//    Data stays stable while respack=0. After beat 7 is acked, respcyc=0 next cycle -> IDLE.
//  - INV_RESP: entered the cycle after the inv handshake. One beat: resp=inv_addr
//    (latched), tag=13'h0800, held until respack -> IDLE.
//  - Reads never interleave with invalidates; an invalidate waits in the source until IDLE.
//  - Beat counter is 3 bits (0..7). Latency counter width is $clog2(READ_LATENCY+1).
// STRUCTURE
//  - sysbus_pkg: tag field constants (TAG_RW_BIT=12, TAG_ID range, TAG_INVALIDATE=13'h0800),
//    BEATS_PER_LINE=8, responder state enum.
//  - Sub-module sysbus_mem_array: MEM_WORDS x 64 with synchronous write and asynchronous read.
//    The FSM plus beat/latency counters live in the top.
// TESTING
//  1. Preload words 8..15 = 0x100+k. Read addr 0x47, tag 0x1100, respack held 1
//     -> one reqack; respcyc rises READ_LATENCY cycles later; beats 0x100..0x107, tag 0x1100.
//  2. Write addr 0x80, tag 0x0100, data 0xA0..0xA7 -> 9 reqack pulses, busy falls;
//     then read 0x80 returns 0xA0..0xA7.
//  3. Read with respack toggling every other cycle -> each beat held until acked;
//     exactly 8 beats, no skip or duplicate.
//  4. inv_valid, inv_addr=0xDEAD40, same cycle as a read reqcyc -> beat 0xDEAD40 with
//     tag 0x0800 first, then the read is accepted and served normally.
//  5. Assert reset after read beat 3 is acked -> next cycle respcyc=0, reqack=0, busy=0;
//     a new read then completes correctly.
//  6. Write line at 0x40, read addr MEM_WORDS*8+0x40 -> same data (wrap-around aliasing).

Source files
------------

// File: rtl/sysbus_pkg.sv
// rtl/sysbus_pkg.sv - shared tag fields, line geometry and responder state encoding
package sysbus_pkg;

    localparam int TAG_RW_BIT     = 12;
    localparam int TAG_ID_HI      = 11;
    localparam int TAG_ID_LO      = 8;
    localparam logic [12:0] TAG_INVALIDATE = 13'h0800;
    localparam int BEATS_PER_LINE = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_DATA  = 3'd1,
        ST_RD_LAT   = 3'd2,
        ST_RD_RESP  = 3'd3,
        ST_INV_RESP = 3'd4
    } resp_state_e;

endpackage

// File: rtl/sysbus_mem_array.sv
// rtl/sysbus_mem_array.sv - word-addressed backing store, synchronous write, asynchronous read
module sysbus_mem_array #(
    parameter int DATA_W = 64,
    parameter int WORDS  = 4096,
    parameter int AW     = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    // Contents survive reset on purpose: the bus end behaves like real memory.
    logic [DATA_W-1:0] mem_q [WORDS];

    // Commit one word per write strobe.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sysbus_mem_responder.sv
// rtl/sysbus_mem_responder.sv - memory end of the Sysbus line protocol with invalidate injection
module sysbus_mem_responder
    import sysbus_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MEM_WORDS      = 4096,
    parameter int READ_LATENCY   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_reqack,
    output logic                      bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    input  logic                      bus_respack,
    input  logic                      inv_valid,
    input  logic [BUS_DATA_WIDTH-1:0] inv_addr,
    output logic                      inv_ready,
    output logic                      busy
);

    localparam int AW    = $clog2(MEM_WORDS);
    localparam int LW    = AW - 3;
    localparam int LAT_W = $clog2(READ_LATENCY + 1);
    localparam logic [2:0] LAST_BEAT = 3'(BEATS_PER_LINE - 1);

    resp_state_e               state_q, state_d;
    logic                      reqack_q, reqack_d;
    logic [LW-1:0]             line_q, line_d;
    logic [BUS_TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [2:0]                beat_q, beat_d;
    logic [LAT_W-1:0]          lat_q, lat_d;
    logic [BUS_DATA_WIDTH-1:0] inv_addr_q, inv_addr_d;

    logic                      accept;
    logic                      mem_we;
    logic [BUS_DATA_WIDTH-1:0] mem_rdata;
    logic                      unused_bits;

    // A beat is taken only while no ack is outstanding, so each beat costs two cycles.
    assign accept      = bus_reqcyc && !reqack_q;
    assign unused_bits = ^{bus_req[BUS_DATA_WIDTH-1:6+LW], bus_req[5:0]};

    sysbus_mem_array #(
        .DATA_W (BUS_DATA_WIDTH),
        .WORDS  (MEM_WORDS),
        .AW     (AW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr ({line_q, beat_q}),
        .wdata (bus_req),
        .raddr ({line_q, beat_q}),
        .rdata (mem_rdata)
    );

    // Next-state logic: beat acceptance, read latency countdown and response sequencing.
    always_comb begin
        state_d    = state_q;
        reqack_d   = 1'b0;
        line_d     = line_q;
        tag_d      = tag_q;
        beat_d     = beat_q;
        lat_d      = lat_q;
        inv_addr_d = inv_addr_q;
        mem_we     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Invalidate wins over a simultaneous request; that request gets no ack.
                if (inv_valid) begin
                    inv_addr_d = inv_addr;
                    state_d    = ST_INV_RESP;
                end else if (accept) begin
                    reqack_d = 1'b1;
                    tag_d    = bus_reqtag;
                    line_d   = bus_req[6 +: LW];
                    beat_d   = 3'd0;
                    if (bus_reqtag[TAG_RW_BIT]) begin
                        lat_d   = LAT_W'(READ_LATENCY);
                        state_d = ST_RD_LAT;
                    end else begin
                        state_d = ST_WR_DATA;
                    end
                end
            end
            ST_WR_DATA: begin
                if (accept) begin
                    reqack_d = 1'b1;
                    mem_we   = !reset;
                    beat_d   = beat_q + 3'd1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RD_LAT: begin
                lat_d = lat_q - LAT_W'(1);
                if (lat_q <= LAT_W'(1)) begin
                    state_d = ST_RD_RESP;
                end
            end
            ST_RD_RESP: begin
                if (bus_respack) begin
                    beat_d = beat_q + 3'd1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_INV_RESP: begin
                if (bus_respack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counter registers; reset aborts any transfer in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            reqack_q   <= 1'b0;
            line_q     <= '0;
            tag_q      <= '0;
            beat_q     <= 3'd0;
            lat_q      <= '0;
            inv_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            reqack_q   <= reqack_d;
            line_q     <= line_d;
            tag_q      <= tag_d;
            beat_q     <= beat_d;
            lat_q      <= lat_d;
            inv_addr_q <= inv_addr_d;
        end
    end

    assign bus_reqack  = reqack_q;
    assign busy        = (state_q != ST_IDLE);
    assign inv_ready   = (state_q == ST_IDLE) && !reset;
    assign bus_respcyc = (state_q == ST_RD_RESP) || (state_q == ST_INV_RESP);
    assign bus_resp    = (state_q == ST_RD_RESP)  ? mem_rdata  :
                         (state_q == ST_INV_RESP) ? inv_addr_q : '0;
    assign bus_resptag = (state_q == ST_RD_RESP)  ? tag_q :
                         (state_q == ST_INV_RESP) ? BUS_TAG_WIDTH'(TAG_INVALIDATE) : '0;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// tb/tb_sysbus_mem_responder.sv - randomized self-checking bench against a line-level memory model
module tb_sysbus_mem_responder;

    localparam int MW = 4096;
    localparam int RL = 4;

    typedef struct {
        logic [63:0] data;
        logic [12:0] tag;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_reqcyc;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_reqack;
    logic        bus_respcyc;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;
    logic        bus_respack;
    logic        inv_valid;
    logic [63:0] inv_addr;
    logic        inv_ready;
    logic        bus_busy;

    int total = 0;
    int bad   = 0;
    int ack_mode = 0;
    int reqack_cnt = 0;
    int acked_cnt = 0;

    logic [63:0] model_mem [int];
    beat_t       exp_q [$];
    logic [63:0] got_q [$];
    logic [12:0] got_tag_q [$];

    sysbus_mem_responder #(
        .BUS_DATA_WIDTH (64),
        .BUS_TAG_WIDTH  (13),
        .MEM_WORDS      (MW),
        .READ_LATENCY   (RL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus_reqcyc  (bus_reqcyc),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_reqack  (bus_reqack),
        .bus_respcyc (bus_respcyc),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag),
        .bus_respack (bus_respack),
        .inv_valid   (inv_valid),
        .inv_addr    (inv_addr),
        .inv_ready   (inv_ready),
        .busy        (bus_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int line_base(input logic [63:0] addr);
        return int'((addr / 64) % (MW / 8)) * 8;
    endfunction

    // Every response beat is compared against the head of the expected queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus_reqack) reqack_cnt++;
            if (bus_respcyc) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(bus_respcyc), 64'd0);
                end else begin
                    chk("resp_data", bus_resp, exp_q[0].data);
                    chk("resp_tag", 64'(bus_resptag), 64'(exp_q[0].tag));
                    if (bus_respack) begin
                        got_q.push_back(bus_resp);
                        got_tag_q.push_back(bus_resptag);
                        void'(exp_q.pop_front());
                        acked_cnt++;
                    end
                end
            end
        end
    end

    // Response-ack pattern: 0 always ready, 1 toggling, 2 random.
    initial begin
        bus_respack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ack_mode)
                0:       bus_respack = 1'b1;
                1:       bus_respack = ~bus_respack;
                default: bus_respack = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic send_beat(input logic [63:0] d, input logic [12:0] t);
        bit ok = 0;
        bus_reqcyc = 1'b1;
        bus_req    = d;
        bus_reqtag = t;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            #1;
            if (bus_reqack) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("reqack_timeout", 64'(bus_reqack), 64'd1);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int n = 0; n < 600; n++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !bus_busy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic push_line(input logic [63:0] addr, input logic [12:0] tag);
        int b;
        beat_t e;
        b = line_base(addr);
        for (int k = 0; k < 8; k++) begin
            e.data = model_mem[b + k];
            e.tag  = tag;
            exp_q.push_back(e);
        end
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [12:0] tag,
                            input logic [63:0] d0, input logic [63:0] step, input bit rnd);
        int b;
        int c0;
        logic [63:0] d;
        b  = line_base(addr);
        c0 = reqack_cnt;
        send_beat(addr, tag);
        for (int k = 0; k < 8; k++) begin
            d = rnd ? {$urandom, $urandom} : d0 + step * 64'(k);
            model_mem[b + k] = d;
            send_beat(d, tag);
        end
        bus_reqcyc = 1'b0;
        chk("wr_busy_after_last", 64'(bus_busy), 64'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("wr_reqack_pulses", 64'(reqack_cnt - c0), 64'd9);
    endtask

    task automatic do_read(input logic [63:0] addr, input logic [12:0] tag, input bit lat_chk);
        int n;
        push_line(addr, tag);
        send_beat(addr, tag);
        bus_reqcyc = 1'b0;
        if (lat_chk) begin
            n = 0;
            while (!bus_respcyc && n < 50) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("rd_latency", 64'(n), 64'(RL));
        end
        wait_idle();
    endtask

    task automatic inv_send(input logic [63:0] a);
        bit ok = 0;
        inv_valid = 1'b1;
        inv_addr  = a;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (inv_ready) begin
                @(posedge clk);
                #1;
                ok = 1;
                break;
            end
        end
        inv_valid = 1'b0;
        if (!ok) chk("inv_ready_timeout", 64'(inv_ready), 64'd1);
    endtask

    task automatic do_inv_read(input logic [63:0] ia, input logic [63:0] addr, input logic [12:0] tag);
        beat_t e;
        e.data = ia;
        e.tag  = 13'h0800;
        exp_q.push_back(e);
        push_line(addr, tag);
        fork
            inv_send(ia);
            send_beat(addr, tag);
        join
        bus_reqcyc = 1'b0;
        wait_idle();
    endtask

    task automatic chk_got_line(input string nm, input int first, input logic [63:0] d0,
                                input logic [12:0] tag);
        chk({nm, "_count"}, 64'(got_q.size()), 64'(first + 8));
        for (int k = 0; k < 8 && first + k < got_q.size(); k++) begin
            chk({nm, "_data"}, got_q[first + k], d0 + 64'(k));
            chk({nm, "_tag"}, 64'(got_tag_q[first + k]), 64'(tag));
        end
    endtask

    initial begin
        int base;
        int lines [4];
        logic [63:0] a;
        lines = '{1, 2, 3, 5};
        reset      = 1'b1;
        bus_reqcyc = 1'b0;
        bus_req    = '0;
        bus_reqtag = '0;
        inv_valid  = 1'b0;
        inv_addr   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_respcyc", 64'(bus_respcyc), 64'd0);
        chk("rst_reqack", 64'(bus_reqack), 64'd0);
        chk("rst_busy", 64'(bus_busy), 64'd0);
        chk("rst_resp", bus_resp, 64'd0);
        chk("rst_resptag", 64'(bus_resptag), 64'd0);
        chk("rst_inv_ready", 64'(inv_ready), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_inv_ready", 64'(inv_ready), 64'd1);

        // Preload words 8..15 and read back through an unaligned address.
        ack_mode = 0;
        do_write(64'h40, 13'h0100, 64'h100, 64'd1, 0);
        got_q.delete();
        got_tag_q.delete();
        do_read(64'h47, 13'h1100, 1);
        chk_got_line("t1", 0, 64'h100, 13'h1100);

        // Writeback then read of the same line.
        do_write(64'h80, 13'h0100, 64'hA0, 64'd1, 0);
        got_q.delete();
        got_tag_q.delete();
        do_read(64'h80, 13'h1200, 1);
        chk_got_line("t2", 0, 64'hA0, 13'h1200);

        // Back-pressured read.
        ack_mode = 1;
        got_q.delete();
        got_tag_q.delete();
        do_read(64'h40, 13'h1300, 0);
        chk_got_line("t3", 0, 64'h100, 13'h1300);

        // Invalidate collides with a read request.
        ack_mode = 0;
        got_q.delete();
        got_tag_q.delete();
        do_inv_read(64'hDEAD40, 64'h80, 13'h1400);
        chk("t4_inv_data", got_q.size() > 0 ? got_q[0] : 64'hX, 64'hDEAD40);
        chk("t4_inv_tag", got_tag_q.size() > 0 ? 64'(got_tag_q[0]) : 64'hX, 64'h0800);
        chk_got_line("t4", 1, 64'hA0, 13'h1400);

        // Reset after beat 3 of a read is acked.
        base = acked_cnt;
        push_line(64'h40, 13'h1500);
        send_beat(64'h40, 13'h1500);
        bus_reqcyc = 1'b0;
        for (int n = 0; n < 100 && acked_cnt < base + 4; n++) begin
            @(posedge clk);
            #1;
        end
        chk("t5_beats_before_reset", 64'(acked_cnt - base), 64'd4);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_respcyc", 64'(bus_respcyc), 64'd0);
        chk("t5_reqack", 64'(bus_reqack), 64'd0);
        chk("t5_busy", 64'(bus_busy), 64'd0);
        reset = 1'b0;
        exp_q.delete();
        got_q.delete();
        got_tag_q.delete();
        do_read(64'h40, 13'h1600, 1);
        chk_got_line("t5_after", 0, 64'h100, 13'h1600);

        // Aliasing beyond the array size.
        do_write(64'h40, 13'h0200, 64'h5000, 64'd3, 0);
        do_read(64'(MW) * 8 + 64'h40, 13'h1700, 0);

        // Randomized mix of writes, reads and invalidates.
        foreach (lines[i]) do_write(64'(lines[i]) * 64, 13'h0300, 64'd0, 64'd0, 1);
        for (int it = 0; it < 40; it++) begin
            ack_mode = int'($urandom_range(0, 2));
            a = (64'($urandom_range(0, 255)) << 15) |
                (64'(lines[$urandom_range(0, 3)]) << 6) | 64'($urandom_range(0, 63));
            case ($urandom_range(0, 3))
                0: do_write(a, {1'b0, 12'($urandom)}, 64'd0, 64'd0, 1);
                1: do_read(a, {1'b1, 12'($urandom)}, 1);
                2: do_inv_read({$urandom, $urandom}, a, {1'b1, 12'($urandom)});
                default: begin
                    beat_t e;
                    e.data = {$urandom, $urandom};
                    e.tag  = 13'h0800;
                    exp_q.push_back(e);
                    inv_send(e.data);
                    wait_idle();
                end
            endcase
        end

        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
